// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: matrix geometry, frame classification and debounce states.
package keypad_scanner_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_KEY,
        FR_MULTI
    } frame_res_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_PRESSED,
        ST_RELEASE
    } scan_state_t;

    function automatic logic [2:0] bit_count(input logic [KEY_COLS-1:0] bits);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < KEY_COLS; i++) begin
            n = n + {2'b00, bits[i]};
        end
        return n;
    endfunction

    // Lowest asserted column wins when reporting the first hit of a frame.
    function automatic logic [1:0] first_col(input logic [KEY_COLS-1:0] bits);
        logic [1:0] col;
        col = '0;
        for (int i = KEY_COLS - 1; i >= 0; i--) begin
            if (bits[i]) col = 2'(i);
        end
        return col;
    endfunction

endpackage

// File: rtl/keypad_row_driver.sv
// Drives one keypad row at a time, synchronizes the bit lines and classifies each full scan.
// Latency: frame result registered one clock after the row-3 sample.
// Backpressure: none; free-running scan, result is a single-cycle strobe.
module keypad_row_driver
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [KEY_ROWS-1:0] word_lines,
    input  logic [KEY_COLS-1:0] bit_lines,
    output logic                frame_done,
    output frame_res_t          frame_result,
    output logic [3:0]          frame_code
);

    localparam int DW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam int RW = $clog2(KEY_ROWS);
    localparam logic [RW-1:0] ROW_LAST = RW'(KEY_ROWS - 1);

    logic [KEY_COLS-1:0] sync1;
    logic [KEY_COLS-1:0] sync2;
    logic [DW-1:0]       dwell;
    logic [RW-1:0]       row;
    logic [1:0]          hits;
    logic [3:0]          first_code;

    logic                sample;
    logic [2:0]          sum;
    logic [1:0]          hits_nxt;
    logic [3:0]          code_nxt;

    assign word_lines = KEY_ROWS'(1) << row;
    assign sample     = (dwell == DWELL_LAST);

    // Hit count saturates at 2: beyond that every frame is simply MULTI.
    always_comb begin
        sum      = {1'b0, hits} + bit_count(sync2);
        hits_nxt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
        code_nxt = first_code;
        if (hits == 2'd0 && sync2 != '0) begin
            code_nxt = {row, first_col(sync2)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1        <= '0;
            sync2        <= '0;
            dwell        <= '0;
            row          <= '0;
            hits         <= '0;
            first_code   <= '0;
            frame_done   <= 1'b0;
            frame_result <= FR_NONE;
            frame_code   <= '0;
        end else begin
            sync1      <= bit_lines;
            sync2      <= sync1;
            frame_done <= 1'b0;
            if (sample) begin
                dwell <= '0;
                row   <= row + RW'(1);
                if (row == ROW_LAST) begin
                    frame_done   <= 1'b1;
                    frame_result <= (hits_nxt == 2'd0) ? FR_NONE :
                                    (hits_nxt == 2'd1) ? FR_KEY : FR_MULTI;
                    frame_code   <= code_nxt;
                    hits         <= '0;
                    first_code   <= '0;
                end else begin
                    hits       <= hits_nxt;
                    first_code <= code_nxt;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounces scan frames and emits one key code per physical press.
// Latency: code valid one clock after the last debounce frame ends.
// Backpressure: valid/ready; a confirm while a code is still pending is dropped and flagged on o_overrun.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] o_word_lines,
    input  logic [3:0] i_bit_lines,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    input  logic       i_key_ready,
    output logic       o_key_held,
    output logic       o_overrun
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic        frame_done;
    frame_res_t  frame_result;
    logic [3:0]  frame_code;

    scan_state_t state;
    logic [CW-1:0] cnt;
    logic [3:0]  cand;
    logic        confirm;
    logic        frame_key;
    logic        frame_none;

    keypad_row_driver #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_row_driver (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_lines   (o_word_lines),
        .bit_lines    (i_bit_lines),
        .frame_done   (frame_done),
        .frame_result (frame_result),
        .frame_code   (frame_code)
    );

    assign frame_key  = frame_done && (frame_result == FR_KEY);
    assign frame_none = frame_done && (frame_result == FR_NONE);

    // A press is confirmed on the frame that completes the run of matching KEY frames.
    always_comb begin
        confirm = 1'b0;
        if (frame_key) begin
            if (state == ST_IDLE && DEBOUNCE_FRAMES == 1) confirm = 1'b1;
            if (state == ST_CAND && frame_code == cand && cnt == CNT_LAST) confirm = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cand        <= '0;
            o_key_held  <= 1'b0;
            o_key_valid <= 1'b0;
            o_key_code  <= '0;
            o_overrun   <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (frame_done) begin
                case (state)
                    ST_IDLE: begin
                        if (frame_key) begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                            if (confirm) begin
                                state      <= ST_PRESSED;
                                o_key_held <= 1'b1;
                            end else begin
                                state <= ST_CAND;
                            end
                        end
                    end
                    ST_CAND: begin
                        if (!frame_key) begin
                            state <= ST_IDLE;
                        end else if (frame_code != cand) begin
                            cand <= frame_code;
                            cnt  <= CW'(1);
                        end else if (confirm) begin
                            state      <= ST_PRESSED;
                            o_key_held <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ST_PRESSED: begin
                        if (frame_none) begin
                            cnt <= CW'(1);
                            if (DEBOUNCE_FRAMES == 1) begin
                                state      <= ST_IDLE;
                                o_key_held <= 1'b0;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (!frame_none) begin
                            state <= ST_PRESSED;
                        end else if (cnt == CNT_LAST) begin
                            state      <= ST_IDLE;
                            o_key_held <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            // A transfer in the same cycle frees the slot, so the new code loads without overrun.
            if (confirm) begin
                if (o_key_valid && !i_key_ready) begin
                    o_overrun <= 1'b1;
                end else begin
                    o_key_valid <= 1'b1;
                    o_key_code  <= frame_code;
                end
            end else if (o_key_valid && i_key_ready) begin
                o_key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Frame-level bench for keypad_scanner: a keypad matrix model plus a debounce/handshake reference model.
module tb_keypad_scanner;

    localparam int DEB = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] word_lines;
    logic [3:0] bit_lines;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    logic [15:0] keys;

    int total;
    int bad;

    // reference model state
    int  m_state;   // 0 idle, 1 candidate, 2 pressed, 3 releasing
    int  m_cand;
    int  m_cnt;
    bit  mv;
    int  mc;
    bit  have_pend;
    int  pend_kind; // 0 none, 1 single key, 2 multi
    int  pend_code;

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_FRAMES (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_word_lines (word_lines),
        .i_bit_lines  (bit_lines),
        .o_key_valid  (key_valid),
        .o_key_code   (key_code),
        .i_key_ready  (key_ready),
        .o_key_held   (key_held),
        .o_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key at index r*4+c connects word line r to bit line c.
    always_comb begin
        bit_lines = '0;
        for (int r = 0; r < 4; r++) begin
            if (word_lines[r]) bit_lines = bit_lines | keys[r*4 +: 4];
        end
    end

    task automatic model_reset();
        m_state   = 0;
        m_cand    = 0;
        m_cnt     = 0;
        mv        = 1'b0;
        mc        = 0;
        have_pend = 1'b0;
        pend_kind = 0;
        pend_code = 0;
    endtask

    // Caller is at the falling edge right after a frame end; runs exactly one frame.
    task automatic do_frame(input logic [15:0] k, input bit rdy);
        bit conf;
        bit xfer;
        bit exp_ov;
        bit exp_held;
        keys      = k;
        key_ready = rdy;
        @(posedge clk); @(negedge clk);

        conf = 1'b0;
        if (have_pend) begin
            case (m_state)
                0: if (pend_kind == 1) begin
                    m_cand = pend_code; m_cnt = 1; m_state = 1;
                    if (m_cnt >= DEB) begin conf = 1'b1; m_state = 2; end
                end
                1: if (pend_kind != 1) m_state = 0;
                   else if (pend_code != m_cand) begin m_cand = pend_code; m_cnt = 1; end
                   else begin
                       m_cnt++;
                       if (m_cnt >= DEB) begin conf = 1'b1; m_state = 2; end
                   end
                2: if (pend_kind == 0) begin
                    m_cnt = 1; m_state = 3;
                    if (m_cnt >= DEB) m_state = 0;
                end
                default: if (pend_kind != 0) m_state = 2;
                   else begin m_cnt++; if (m_cnt >= DEB) m_state = 0; end
            endcase
        end
        xfer   = mv && rdy;
        exp_ov = 1'b0;
        if (conf) begin
            if (mv && !xfer) exp_ov = 1'b1;
            else begin mv = 1'b1; mc = m_cand; end
        end else if (xfer) begin
            mv = 1'b0;
        end
        exp_held = (m_state == 2 || m_state == 3);

        total++;
        if (key_valid !== mv) begin
            bad++; $display("FAIL valid_at_frame_end got=%b exp=%b t=%0t", key_valid, mv, $time);
        end
        if (mv) begin
            total++;
            if (key_code !== 4'(mc)) begin
                bad++; $display("FAIL key_code got=%0d exp=%0d t=%0t", key_code, mc, $time);
            end
        end
        total++;
        if (overrun !== exp_ov) begin
            bad++; $display("FAIL overrun_pulse got=%b exp=%b t=%0t", overrun, exp_ov, $time);
        end
        total++;
        if (key_held !== exp_held) begin
            bad++; $display("FAIL key_held got=%b exp=%b t=%0t", key_held, exp_held, $time);
        end

        @(posedge clk); @(negedge clk);
        if (rdy && mv) mv = 1'b0;
        total++;
        if (key_valid !== mv) begin
            bad++; $display("FAIL valid_after_ready got=%b exp=%b t=%0t", key_valid, mv, $time);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL overrun_width got=%b exp=0 t=%0t", overrun, $time);
        end
        key_ready = 1'b0;

        repeat (14) @(posedge clk);
        @(negedge clk);
        have_pend = 1'b1;
        pend_kind = ($countones(k) == 0) ? 0 : ($countones(k) == 1) ? 1 : 2;
        pend_code = 0;
        for (int i = 15; i >= 0; i--) if (k[i]) pend_code = i;
    endtask

    task automatic test_reset();
        int guard;
        keys      = '0;
        key_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        guard = 0;
        while (word_lines !== 4'b0100 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (word_lines !== 4'b0100) begin
            bad++; $display("FAIL reach_row2 got=%b exp=0100", word_lines);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (word_lines !== 4'b0001) begin
            bad++; $display("FAIL reset_word_lines got=%b exp=0001", word_lines);
        end
        total++;
        if ({key_valid, key_held, overrun} !== 3'b000) begin
            bad++; $display("FAIL reset_outputs got=%b exp=000", {key_valid, key_held, overrun});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < 16; j++) begin
            total++;
            if (word_lines !== 4'(1 << ((j / 4) % 4))) begin
                bad++; $display("FAIL row_sequence cycle=%0d got=%b exp=%b", j, word_lines, 4'(1 << ((j / 4) % 4)));
            end
            @(posedge clk); @(negedge clk);
        end
        have_pend = 1'b1;
        pend_kind = 0;
        pend_code = 0;
    endtask

    task automatic test_clean_press();
        repeat (3) do_frame(16'h0200, 1'b0);
        total++;
        if (key_valid !== 1'b0) begin
            bad++; $display("FAIL latency_early got=%b exp=0", key_valid);
        end
        repeat (2) do_frame(16'h0200, 1'b0);
        do_frame(16'h0200, 1'b1);
    endtask

    task automatic test_release_debounce();
        repeat (2) do_frame(16'h0000, 1'b0);
        repeat (3) do_frame(16'h0200, 1'b0);
        repeat (3) do_frame(16'h0000, 1'b0);
        repeat (3) do_frame(16'h0200, 1'b0);
        do_frame(16'h0200, 1'b1);
        repeat (4) do_frame(16'h0000, 1'b0);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) do_frame((i % 2 == 0) ? 16'h0200 : 16'h0000, 1'b0);
        repeat (2) do_frame(16'h0000, 1'b0);
    endtask

    task automatic test_multi_key();
        repeat (6) do_frame(16'h0021, 1'b0);
        repeat (3) do_frame(16'h0001, 1'b0);
        do_frame(16'h0001, 1'b1);
        repeat (4) do_frame(16'h0000, 1'b0);
    endtask

    task automatic test_overrun();
        repeat (3) do_frame(16'h0008, 1'b0);
        repeat (4) do_frame(16'h0000, 1'b0);
        repeat (3) do_frame(16'h1000, 1'b0);
        repeat (4) do_frame(16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        repeat (3) do_frame(16'h0080, 1'b0);
        do_frame(16'h0000, 1'b1);
        repeat (4) do_frame(16'h0000, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int r;
        k = '0;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (r == 5 || r == 6) k = '0;
            else if (r == 7 || r == 8) k = 16'(1 << $urandom_range(0, 15));
            else if (r == 9) k = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
            do_frame(k, $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        test_reset();
        test_clean_press();
        test_release_debounce();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
